clkgen_sequencer: RTL

- Command-driven controller for the programmable clock frequency divider.
- Accepts {divisor, period count} commands over a valid/ready handshake.
- Programs the divider only while it is disabled, enables it for exactly the requested number of output periods, then stops it and signals completion.
- Sits between the register/command layer and the divider's Din/ConfigDiv/Enable inputs.

---
 rtl/clkgen_sequencer_if.sv | 13 +
 rtl/clkgen_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/clkgen_sequencer_if.sv
// Command handshake between the register/command layer and the clock divider sequencer.
interface clkgen_sequencer_if #(
  parameter int unsigned DIV_W = 32,
  parameter int unsigned CNT_W = 16
);
  logic             CmdValid;
  logic             CmdReady;
  logic [DIV_W-1:0] CmdDiv;
  logic [CNT_W-1:0] CmdPeriods;

  modport master (output CmdValid, output CmdDiv, output CmdPeriods, input CmdReady);
  modport slave  (input CmdValid, input CmdDiv, input CmdPeriods, output CmdReady);
endinterface

// File: rtl/clkgen_sequencer.sv
// Sequences the clock divider: programs it while disabled, enables it for a fixed
// number of divided periods, then stops it and reports Done or Aborted.
module clkgen_sequencer #(
  parameter int unsigned DIV_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  clkgen_sequencer_if.slave cmd,
  input  logic             Abort,
  output logic [DIV_W-1:0] DivDin,
  output logic             DivConfig,
  output logic             DivEnable,
  output logic             Busy,
  output logic             Done,
  output logic             Aborted,
  output logic [CNT_W-1:0] PeriodsLeft
);

  typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_RUN} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] phase_q;
  logic [DIV_W-1:0] din_q;
  logic [CNT_W-1:0] left_q;
  logic             config_q;
  logic             enable_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             accept;

  // Divisors 0 and 1 both mean pass-through.
  always_comb begin
    div_d = cmd.CmdDiv;
    if (cmd.CmdDiv <= DIV_W'(1)) div_d = DIV_W'(1);
  end

  assign cmd.CmdReady = (state_q == S_IDLE) && !Abort;
  assign accept       = cmd.CmdValid && cmd.CmdReady;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      div_q     <= DIV_W'(1);
      phase_q   <= DIV_W'(1);
      din_q     <= DIV_W'(1);
      left_q    <= '0;
      config_q  <= 1'b0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            div_q  <= div_d;
            left_q <= cmd.CmdPeriods;
            if (cmd.CmdPeriods == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= S_CONFIG;
              din_q    <= div_d;
              config_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end
        S_CONFIG, S_RUN: begin
          if (Abort) begin
            state_q   <= S_IDLE;
            config_q  <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            left_q    <= '0;
            phase_q   <= DIV_W'(1);
            aborted_q <= 1'b1;
          end else if (state_q == S_CONFIG) begin
            state_q  <= S_RUN;
            config_q <= 1'b0;
            enable_q <= 1'b1;
            phase_q  <= DIV_W'(1);
          end else if (phase_q == div_q) begin
            // One divided period finished; the last one ends the run.
            phase_q <= DIV_W'(1);
            left_q  <= left_q - CNT_W'(1);
            if (left_q == CNT_W'(1)) begin
              state_q  <= S_IDLE;
              enable_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + DIV_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DivDin      = din_q;
  assign DivConfig   = config_q;
  assign DivEnable   = enable_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Aborted     = aborted_q;
  assign PeriodsLeft = left_q;

endmodule
